// File: rtl/muntjac_metadata_fsm_table.sv
// Runtime-programmable metadata transition table (next = T[event][state]) with
// independent registered lookup ports, a CSR write port and exception counters.
module muntjac_metadata_fsm_table #(
  parameter int StateWidth = 8,
  parameter int EventWidth = 4,
  parameter int NumStates  = 64,
  parameter int NumEvents  = 4,
  parameter int NumPorts   = 2,
  parameter int ExcState   = 50,
  parameter int CntWidth   = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumPorts-1:0]            req_valid_i,
  output logic [NumPorts-1:0]            req_ready_o,
  input  logic [NumPorts*StateWidth-1:0] req_state_i,
  input  logic [NumPorts*EventWidth-1:0] req_event_i,
  output logic [NumPorts-1:0]            rsp_valid_o,
  input  logic [NumPorts-1:0]            rsp_ready_i,
  output logic [NumPorts*StateWidth-1:0] rsp_state_o,
  output logic [NumPorts-1:0]            rsp_exc_o,
  output logic [NumPorts-1:0]            rsp_err_o,
  input  logic                           cfg_we_i,
  input  logic [EventWidth-1:0]          cfg_event_i,
  input  logic [StateWidth-1:0]          cfg_state_i,
  input  logic [StateWidth-1:0]          cfg_data_i,
  output logic                           cfg_err_o,
  output logic [NumPorts*CntWidth-1:0]   exc_cnt_o
);

  localparam int SIdxW = $clog2(NumStates);
  localparam int EIdxW = $clog2(NumEvents);

  logic [StateWidth-1:0]          table_r [NumEvents][NumStates];
  logic [NumPorts-1:0]            rsp_valid_r;
  logic [NumPorts-1:0]            rsp_exc_r;
  logic [NumPorts-1:0]            rsp_err_r;
  logic [NumPorts*StateWidth-1:0] rsp_state_r;
  logic [NumPorts*CntWidth-1:0]   exc_cnt_r;
  logic                           cfg_err_r;

  logic [NumPorts-1:0]            ready_s;
  logic [NumPorts-1:0]            accept_s;
  logic [NumPorts-1:0]            lk_err_s;
  logic [NumPorts-1:0]            lk_exc_s;
  logic [NumPorts*StateWidth-1:0] lk_state_s;
  logic                           cfg_in_range_s;

  function automatic logic idx_in_range(input logic [StateWidth-1:0] st,
                                        input logic [EventWidth-1:0] ev);
    return (32'(st) < 32'(NumStates)) && (32'(ev) < 32'(NumEvents));
  endfunction

  assign cfg_in_range_s = idx_in_range(cfg_state_i, cfg_event_i);

  // Per-port handshake and table read; the read sees the pre-write table contents
  always_comb begin
    ready_s    = '0;
    accept_s   = '0;
    lk_err_s   = '0;
    lk_exc_s   = '0;
    lk_state_s = '0;
    for (int p = 0; p < NumPorts; p++) begin
      ready_s[p]  = !rsp_valid_r[p] || rsp_ready_i[p];
      accept_s[p] = req_valid_i[p] && ready_s[p];
      if (idx_in_range(req_state_i[p*StateWidth +: StateWidth],
                       req_event_i[p*EventWidth +: EventWidth])) begin
        lk_state_s[p*StateWidth +: StateWidth] =
          table_r[req_event_i[p*EventWidth +: EIdxW]][req_state_i[p*StateWidth +: SIdxW]];
        lk_exc_s[p] = (lk_state_s[p*StateWidth +: StateWidth] == StateWidth'(ExcState));
        lk_err_s[p] = 1'b0;
      end else begin
        lk_state_s[p*StateWidth +: StateWidth] = req_state_i[p*StateWidth +: StateWidth];
        lk_exc_s[p] = 1'b0;
        lk_err_s[p] = 1'b1;
      end
    end
  end

  // Table storage: identity after reset, updated by in-range CSR writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < NumEvents; e++) begin
        for (int s = 0; s < NumStates; s++) begin
          table_r[e][s] <= StateWidth'(s);
        end
      end
    end else if (cfg_we_i && cfg_in_range_s) begin
      table_r[cfg_event_i[EIdxW-1:0]][cfg_state_i[SIdxW-1:0]] <= cfg_data_i;
    end
  end

  // Single-cycle error pulse for rejected writes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_err_r <= 1'b0;
    end else begin
      cfg_err_r <= cfg_we_i && !cfg_in_range_s;
    end
  end

  // Response registers: load on accept, hold while stalled, drop valid once consumed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_r <= '0;
      rsp_exc_r   <= '0;
      rsp_err_r   <= '0;
      rsp_state_r <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (accept_s[p]) begin
          rsp_valid_r[p]                          <= 1'b1;
          rsp_exc_r[p]                            <= lk_exc_s[p];
          rsp_err_r[p]                            <= lk_err_s[p];
          rsp_state_r[p*StateWidth +: StateWidth] <= lk_state_s[p*StateWidth +: StateWidth];
        end else if (rsp_ready_i[p]) begin
          rsp_valid_r[p] <= 1'b0;
        end
      end
    end
  end

  // Saturating per-port exception counters, bumped once at acceptance
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exc_cnt_r <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (accept_s[p] && lk_exc_s[p] &&
            (exc_cnt_r[p*CntWidth +: CntWidth] != {CntWidth{1'b1}})) begin
          exc_cnt_r[p*CntWidth +: CntWidth] <= exc_cnt_r[p*CntWidth +: CntWidth] + CntWidth'(1);
        end
      end
    end
  end

  assign req_ready_o = ready_s;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_state_o = rsp_state_r;
  assign rsp_exc_o   = rsp_exc_r;
  assign rsp_err_o   = rsp_err_r;
  assign cfg_err_o   = cfg_err_r;
  assign exc_cnt_o   = exc_cnt_r;

endmodule

// File: tb/tb_muntjac_metadata_fsm_table.sv
// Bench for muntjac_metadata_fsm_table: directed scenarios plus random traffic
// against a table/queue model; a second instance uses 2-bit counters for saturation.
module tb_muntjac_metadata_fsm_table;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  rsp_ready = 2'b11;
  logic [15:0] req_state = 16'h0000;
  logic [7:0]  req_event = 8'h00;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_event = 4'h0;
  logic [7:0]  cfg_state = 8'h00;
  logic [7:0]  cfg_data = 8'h00;

  logic [1:0]  req_ready, rsp_valid, rsp_exc, rsp_err;
  logic [15:0] rsp_state;
  logic        cfg_err;
  logic [31:0] exc_cnt;
  logic [1:0]  req_ready2, rsp_valid2, rsp_exc2, rsp_err2;
  logic [15:0] rsp_state2;
  logic        cfg_err2;
  logic [3:0]  exc_cnt2;

  muntjac_metadata_fsm_table dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_state_i(req_state), .req_event_i(req_event),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_state_o(rsp_state), .rsp_exc_o(rsp_exc), .rsp_err_o(rsp_err),
    .cfg_we_i(cfg_we), .cfg_event_i(cfg_event), .cfg_state_i(cfg_state),
    .cfg_data_i(cfg_data), .cfg_err_o(cfg_err), .exc_cnt_o(exc_cnt)
  );

  muntjac_metadata_fsm_table #(.CntWidth(2)) dut_c2 (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready2),
    .req_state_i(req_state), .req_event_i(req_event),
    .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready),
    .rsp_state_o(rsp_state2), .rsp_exc_o(rsp_exc2), .rsp_err_o(rsp_err2),
    .cfg_we_i(cfg_we), .cfg_event_i(cfg_event), .cfg_state_i(cfg_state),
    .cfg_data_i(cfg_data), .cfg_err_o(cfg_err2), .exc_cnt_o(exc_cnt2)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nfail = 0;

  // reference model
  int tbl [4][64];
  bit m_valid [2];
  int m_state [2];
  bit m_exc [2];
  bit m_err [2];
  int m_cnt [2];
  int m_cnt2 [2];
  bit m_cfg_err;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int e = 0; e < 4; e++)
      for (int s = 0; s < 64; s++) tbl[e][s] = s;
    for (int p = 0; p < 2; p++) begin
      m_valid[p] = 1'b0; m_state[p] = 0; m_exc[p] = 1'b0; m_err[p] = 1'b0;
      m_cnt[p] = 0; m_cnt2[p] = 0;
    end
    m_cfg_err = 1'b0;
  endtask

  task automatic set_req(input int p, input bit v, input int s, input int e);
    req_valid[p] = v;
    req_state[p*8 +: 8] = 8'(s);
    req_event[p*4 +: 4] = 4'(e);
  endtask

  task automatic set_cfg(input bit we, input int e, input int s, input int d);
    cfg_we = we; cfg_event = 4'(e); cfg_state = 8'(s); cfg_data = 8'(d);
  endtask

  task automatic idle();
    set_req(0, 1'b0, 0, 0);
    set_req(1, 1'b0, 0, 0);
    set_cfg(1'b0, 0, 0, 0);
    rsp_ready = 2'b11;
  endtask

  // One clock: check ready, advance the model from pre-edge inputs, compare after the edge.
  task automatic step();
    int s, e, v;
    #1;
    for (int p = 0; p < 2; p++) begin
      check_eq("req_ready", 32'(req_ready[p]), 32'(!m_valid[p] || rsp_ready[p]));
      s = int'(req_state[p*8 +: 8]);
      e = int'(req_event[p*4 +: 4]);
      if (req_valid[p] && (!m_valid[p] || rsp_ready[p])) begin
        m_valid[p] = 1'b1;
        if (s < 64 && e < 4) begin
          v = tbl[e][s];
          m_state[p] = v; m_err[p] = 1'b0; m_exc[p] = (v == 50);
          if (v == 50) begin
            if (m_cnt[p] < 65535) m_cnt[p]++;
            if (m_cnt2[p] < 3) m_cnt2[p]++;
          end
        end else begin
          m_state[p] = s; m_err[p] = 1'b1; m_exc[p] = 1'b0;
        end
      end else if (rsp_ready[p]) begin
        m_valid[p] = 1'b0;
      end
    end
    m_cfg_err = cfg_we && !(cfg_event < 4 && cfg_state < 64);
    if (cfg_we && cfg_event < 4 && cfg_state < 64) tbl[cfg_event][cfg_state] = int'(cfg_data);
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      check_eq("rsp_valid", 32'(rsp_valid[p]), 32'(m_valid[p]));
      check_eq("rsp_valid_c2", 32'(rsp_valid2[p]), 32'(m_valid[p]));
      if (m_valid[p]) begin
        check_eq("rsp_state", 32'(rsp_state[p*8 +: 8]), 32'(m_state[p]));
        check_eq("rsp_state_c2", 32'(rsp_state2[p*8 +: 8]), 32'(m_state[p]));
        check_eq("rsp_exc", 32'(rsp_exc[p]), 32'(m_exc[p]));
        check_eq("rsp_err", 32'(rsp_err[p]), 32'(m_err[p]));
      end
      check_eq("exc_cnt", 32'(exc_cnt[p*16 +: 16]), 32'(m_cnt[p]));
      check_eq("exc_cnt_c2", 32'(exc_cnt2[p*2 +: 2]), 32'(m_cnt2[p]));
    end
    check_eq("cfg_err", 32'(cfg_err), 32'(m_cfg_err));
  endtask

  initial begin
    model_reset();
    idle();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset_rsp_state", 32'(rsp_state), 32'd0);
    check_eq("reset_exc_err", 32'({rsp_exc, rsp_err}), 32'd0);
    check_eq("reset_cfg_err", 32'(cfg_err), 32'd0);
    check_eq("reset_exc_cnt", exc_cnt, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // identity lookup
    set_req(0, 1'b1, 7, 1); step(); idle();
    check_eq("t1_state", 32'(rsp_state[7:0]), 32'd7);
    check_eq("t1_valid", 32'(rsp_valid[0]), 32'd1);
    step();

    // program an exception entry, both ports hit it together
    set_cfg(1'b1, 2, 0, 50); step(); idle();
    set_req(0, 1'b1, 0, 2); set_req(1, 1'b1, 0, 2); step(); idle();
    check_eq("t2_state0", 32'(rsp_state[7:0]), 32'd50);
    check_eq("t2_state1", 32'(rsp_state[15:8]), 32'd50);
    check_eq("t2_exc", 32'(rsp_exc), 32'd3);
    check_eq("t2_cnt0", 32'(exc_cnt[15:0]), 32'd1);
    check_eq("t2_cnt1", 32'(exc_cnt[31:16]), 32'd1);

    // read-before-write on the same entry
    set_cfg(1'b1, 1, 3, 9); set_req(1, 1'b1, 3, 1); step(); idle();
    check_eq("t3_old", 32'(rsp_state[15:8]), 32'd3);
    set_req(1, 1'b1, 3, 1); step(); idle();
    check_eq("t3_new", 32'(rsp_state[15:8]), 32'd9);

    // backpressure: stall 3 cycles then resume at full rate
    set_req(0, 1'b1, 5, 0); step();
    rsp_ready[0] = 1'b0; set_req(0, 1'b1, 9, 1);
    repeat (3) step();
    check_eq("t4_held", 32'(rsp_state[7:0]), 32'd5);
    rsp_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, 10 + i, 0); step();
      check_eq("t4_b2b", 32'(rsp_state[7:0]), 32'(10 + i));
    end
    idle(); step();

    // out-of-range write and lookup
    set_cfg(1'b1, 4, 1, 33); step(); idle();
    check_eq("t5_cfg_err_pulse", 32'(cfg_err), 32'd1);
    set_req(0, 1'b1, 70, 0); step(); idle();
    check_eq("t5_cfg_err_clear", 32'(cfg_err), 32'd0);
    check_eq("t5_rsp_err", 32'(rsp_err[0]), 32'd1);
    check_eq("t5_rsp_state", 32'(rsp_state[7:0]), 32'd70);

    // counter saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      set_req(0, 1'b1, 0, 2); step();
    end
    idle(); step();
    check_eq("t6_cnt2_sat", 32'(exc_cnt2[1:0]), 32'd3);
    check_eq("t6_cnt16", 32'(exc_cnt[15:0]), 32'd6);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < 2; p++) begin
        set_req(p, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 9) == 0) ? $urandom_range(64, 255) : $urandom_range(0, 7),
                ($urandom_range(0, 9) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3));
        rsp_ready[p] = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 3) == 0)
        set_cfg(1'b1,
                ($urandom_range(0, 7) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? $urandom_range(64, 255) : $urandom_range(0, 7),
                ($urandom_range(0, 2) == 0) ? 50 : $urandom_range(0, 63));
      else
        set_cfg(1'b0, 0, 0, 0);
      step();
    end

    // asynchronous reset with a response pending
    idle();
    set_cfg(1'b1, 2, 0, 50); step(); idle();
    set_req(0, 1'b1, 0, 2); rsp_ready[0] = 1'b0; step();
    check_eq("t7_pending", 32'(rsp_valid[0]), 32'd1);
    rst_ni = 1'b0;
    #1;
    check_eq("t7_rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("t7_rst_cnt", exc_cnt, 32'd0);
    check_eq("t7_rst_cnt2", 32'(exc_cnt2), 32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    model_reset();
    idle();
    set_req(0, 1'b1, 0, 2); step(); idle();
    check_eq("t7_identity", 32'(rsp_state[7:0]), 32'd0);
    check_eq("t7_no_exc", 32'(rsp_exc[0]), 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
